// File: rtl/imem_loader.sv
// imem_loader: turns a framed host byte stream into one instruction-memory byte write per cycle.
// Define LOAD_CSUM_EN to add a trailing XOR checksum byte per frame and check it.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              load_err
);

  typedef enum logic [3:0] {
    IDLE,
    A_HI,
    A_LO,
    L_HI,
    L_LO,
    DATA,
    DRAIN,
`ifdef LOAD_CSUM_EN
    CSUM,
`endif
    END
  } state_e;

  // Where a frame goes once its payload (written or drained) is exhausted.
`ifdef LOAD_CSUM_EN
  localparam state_e PAYLOAD_DONE = CSUM;
`else
  localparam state_e PAYLOAD_DONE = END;
`endif

  localparam logic [16:0] MEM_SIZE = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        mdata_q, mdata_d;
`ifdef LOAD_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_w;
  logic [16:0] end_addr;
  logic        bad_frame;

  assign in_ready  = !reset && (state_q != END);
  assign accept    = in_valid && in_ready;
  assign len_w     = {len_hi_q, in_data};
  assign end_addr  = {1'b0, addr_q} + {1'b0, len_w};
  assign bad_frame = ({1'b0, addr_q} >= MEM_SIZE) || (end_addr > MEM_SIZE);

  assign busy     = (state_q != IDLE) && (state_q != A_HI);
  assign done     = (state_q == END);
  assign load_err = err_q;
  assign mem_wEn  = wen_q;
  assign mem_addr = maddr_q;
  assign mem_data = mdata_q;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    addr_d   = addr_q;
    len_hi_d = len_hi_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wen_d    = 1'b0;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
`ifdef LOAD_CSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      IDLE, A_HI: if (accept) begin
        addr_d  = {in_data, 8'h00};
        err_d   = 1'b0;
`ifdef LOAD_CSUM_EN
        csum_d  = 8'h00;
`endif
        state_d = A_LO;
      end
      A_LO: if (accept) begin
        addr_d  = {addr_q[15:8], in_data};
        state_d = L_HI;
      end
      L_HI: if (accept) begin
        len_hi_d = in_data;
        state_d  = L_LO;
      end
      L_LO: if (accept) begin
        ptr_d = addr_q[ADDR_W-1:0];
        cnt_d = len_w;
        if (bad_frame) begin
          err_d   = 1'b1;
          state_d = (len_w == 16'd0) ? PAYLOAD_DONE : DRAIN;
        end else begin
          state_d = (len_w == 16'd0) ? PAYLOAD_DONE : DATA;
        end
      end
      DATA: if (accept) begin
        wen_d   = 1'b1;
        maddr_d = ptr_q;
        mdata_d = in_data;
        ptr_d   = ptr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 16'd1;
`ifdef LOAD_CSUM_EN
        csum_d  = csum_q ^ in_data;
`endif
        if (cnt_q == 16'd1) state_d = PAYLOAD_DONE;
      end
      DRAIN: if (accept) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = PAYLOAD_DONE;
      end
`ifdef LOAD_CSUM_EN
      // Mismatch only ever sets the flag; data already written stays written.
      CSUM: if (accept) begin
        if (in_data != csum_q) err_d = 1'b1;
        state_d = END;
      end
`endif
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked block rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_hi_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= '0;
`ifdef LOAD_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_hi_q <= len_hi_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wen_q    <= wen_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
`ifdef LOAD_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, stalled, out-of-range, empty, boundary and mid-frame reset frames.
// Checksum steps are included when LOAD_CSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wEn;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        load_err;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  int base;

  imem_loader #(.ADDR_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_wEn  (mem_wEn),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_wEn === 1'b1) wr_count++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_hdr(input logic [15:0] a, input logic [15:0] l);
    send(a[15:8]);
    send(a[7:0]);
    send(l[15:8]);
    send(l[7:0]);
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] a, input logic [7:0] d);
    chk({tag, "_wen"}, {31'd0, mem_wEn}, 32'd1);
    chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, a});
    chk({tag, "_data"}, {24'd0, mem_data}, {24'd0, d});
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wen",   {31'd0, mem_wEn},  32'd0);
    chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
    chk("rst_data",  {24'd0, mem_data}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_err",   {31'd0, load_err}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back frame: 0x0010..0x0012 = AA BB CC.
    base = wr_count;
    send_hdr(16'h0010, 16'h0003);
    chk("f1_busy", {31'd0, busy}, 32'd1);
    chk("f1_nowr_hdr", {31'd0, mem_wEn}, 32'd0);
    send(8'hAA); chk_wr("f1_w0", 16'h0010, 8'hAA);
    send(8'hBB); chk_wr("f1_w1", 16'h0011, 8'hBB);
    send(8'hCC); chk_wr("f1_w2", 16'h0012, 8'hCC);
`ifdef LOAD_CSUM_EN
    chk("f1_done_early", {31'd0, done}, 32'd0);
    send(8'hDD);
    chk("f1_csum_nowr", {31'd0, mem_wEn}, 32'd0);
`endif
    chk("f1_done",  {31'd0, done},     32'd1);
    chk("f1_ready_end", {31'd0, in_ready}, 32'd0);
    chk("f1_err",   {31'd0, load_err}, 32'd0);
    tick();
    chk("f1_done_clr", {31'd0, done},     32'd0);
    chk("f1_idle",     {31'd0, busy},     32'd0);
    chk("f1_ready",    {31'd0, in_ready}, 32'd1);
    chk("f1_nwr", wr_count - base, 32'd3);

    // Same frame with a stall cycle after every byte.
    base = wr_count;
    send(8'h00); tick(); chk("f2_stall_h0", {31'd0, mem_wEn}, 32'd0);
    send(8'h10); tick();
    send(8'h00); tick();
    send(8'h03); tick(); chk("f2_stall_h3", {31'd0, mem_wEn}, 32'd0);
    send(8'hAA); chk_wr("f2_w0", 16'h0010, 8'hAA);
    tick(); chk("f2_stall_w0", {31'd0, mem_wEn}, 32'd0);
    send(8'hBB); chk_wr("f2_w1", 16'h0011, 8'hBB);
    tick(); chk("f2_stall_w1", {31'd0, mem_wEn}, 32'd0);
    send(8'hCC); chk_wr("f2_w2", 16'h0012, 8'hCC);
`ifdef LOAD_CSUM_EN
    tick(); chk("f2_stall_w2", {31'd0, mem_wEn}, 32'd0);
    send(8'hDD);
`endif
    chk("f2_done", {31'd0, done}, 32'd1);
    tick();
    chk("f2_nwr", wr_count - base, 32'd3);

    // Out-of-range frame FFFF + 2: flagged after LEN_L, payload drained without writes.
    base = wr_count;
    send_hdr(16'hFFFF, 16'h0002);
    chk("f3_err_now", {31'd0, load_err}, 32'd1);
    chk("f3_busy", {31'd0, busy}, 32'd1);
    send(8'h11); chk("f3_drain0", {31'd0, mem_wEn}, 32'd0);
    chk("f3_ready_drain", {31'd0, in_ready}, 32'd1);
    send(8'h22); chk("f3_drain1", {31'd0, mem_wEn}, 32'd0);
`ifdef LOAD_CSUM_EN
    send(8'h33);
`endif
    chk("f3_done", {31'd0, done}, 32'd1);
    tick();
    chk("f3_err_held", {31'd0, load_err}, 32'd1);
    chk("f3_nwr", wr_count - base, 32'd0);

    // Empty frame 1234/0: clears the error on ADDR_H, finishes with no writes.
    base = wr_count;
    send(8'h12);
    chk("f4_err_clr", {31'd0, load_err}, 32'd0);
    send(8'h34);
    send(8'h00);
    send(8'h00);
`ifdef LOAD_CSUM_EN
    chk("f4_wait_csum", {31'd0, done}, 32'd0);
    send(8'h00);
`endif
    chk("f4_done", {31'd0, done}, 32'd1);
    chk("f4_err",  {31'd0, load_err}, 32'd0);
    tick();
    chk("f4_nwr", wr_count - base, 32'd0);

    // Last-byte boundary: FFFF + 1 is legal.
    send_hdr(16'hFFFF, 16'h0001);
    chk("f5_err", {31'd0, load_err}, 32'd0);
    send(8'h5A); chk_wr("f5_w0", 16'hFFFF, 8'h5A);
`ifdef LOAD_CSUM_EN
    send(8'h5A);
`endif
    chk("f5_done", {31'd0, done}, 32'd1);
    tick();

    // Reset after the second data byte of a four-byte frame.
    base = wr_count;
    send_hdr(16'h0100, 16'h0004);
    send(8'h01); chk_wr("f6_w0", 16'h0100, 8'h01);
    send(8'h02); chk_wr("f6_w1", 16'h0101, 8'h02);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h03;
    tick();
    chk("f6_rst_wen",   {31'd0, mem_wEn},  32'd0);
    chk("f6_rst_addr",  {16'd0, mem_addr}, 32'd0);
    chk("f6_rst_data",  {24'd0, mem_data}, 32'd0);
    chk("f6_rst_busy",  {31'd0, busy},     32'd0);
    chk("f6_rst_done",  {31'd0, done},     32'd0);
    chk("f6_rst_ready", {31'd0, in_ready}, 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    chk("f6_ready", {31'd0, in_ready}, 32'd1);
    chk("f6_busy",  {31'd0, busy},     32'd0);
    chk("f6_nwr", wr_count - base, 32'd2);
    send_hdr(16'h0020, 16'h0001);
    send(8'h77); chk_wr("f6_fresh", 16'h0020, 8'h77);
`ifdef LOAD_CSUM_EN
    send(8'h77);
`endif
    chk("f6_done", {31'd0, done}, 32'd1);
    tick();

`ifdef LOAD_CSUM_EN
    // Bad checksum: both bytes still written, error raised at the checksum byte.
    send_hdr(16'h0000, 16'h0002);
    send(8'h0F); chk_wr("c1_w0", 16'h0000, 8'h0F);
    send(8'hF0); chk_wr("c1_w1", 16'h0001, 8'hF0);
    send(8'h00);
    chk("c1_err",  {31'd0, load_err}, 32'd1);
    chk("c1_done", {31'd0, done},     32'd1);
    tick();
    send_hdr(16'h0000, 16'h0002);
    send(8'h0F);
    send(8'hF0);
    send(8'hFF);
    chk("c2_err",  {31'd0, load_err}, 32'd0);
    chk("c2_done", {31'd0, done},     32'd1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
